// File: rtl/mem_access_unit.sv
// Initiator-side front end for the single-port word data memory: byte/half/word
// loads and stores over valid/ready, with read-modify-write for sub-word stores.
module mem_access_unit #(
  parameter int addresswidth = 32,
  parameter int depth        = 100000,
  parameter int width        = 32
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    reqValid,
  output logic                    reqReady,
  input  logic                    reqWrite,
  input  logic [1:0]              reqSize,
  input  logic                    reqSigned,
  input  logic [31:0]             reqAddr,
  input  logic [width-1:0]        reqData,
  output logic                    respValid,
  input  logic                    respReady,
  output logic [width-1:0]        respData,
  output logic                    respError,
  output logic [addresswidth-1:0] memAddress,
  output logic                    memWriteEnable,
  output logic [width-1:0]        memDataIn,
  input  logic [width-1:0]        memDataOut
);

  // state   | meaning
  // IDLE    | ready for a request
  // ISSUE   | address presented; word stores write here
  // CAPTURE | read data available, extract and extend the load lane
  // MERGE   | read data available, write back with the lane replaced
  // RESP    | response held until respReady
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, MERGE, RESP} state_t;

  state_t state_q, state_d;

  logic             write_q, signed_q;
  logic [1:0]       size_q, addr_lo_q;
  logic [width-1:0] data_q;

  logic [31:0]      word_idx;
  logic             req_err;
  logic [7:0]       byte_lane;
  logic [15:0]      half_lane;
  logic [width-1:0] load_val, merged;

  assign word_idx = {2'b00, reqAddr[31:2]};

  always_comb begin
    req_err = 1'b0;
    if (reqSize == 2'b11)                          req_err = 1'b1;
    if (reqSize == 2'b01 && reqAddr[0])            req_err = 1'b1;
    if (reqSize == 2'b10 && reqAddr[1:0] != 2'b00) req_err = 1'b1;
    if (word_idx >= 32'(depth))                    req_err = 1'b1;
  end

  assign byte_lane = memDataOut[{addr_lo_q, 3'b000} +: 8];
  assign half_lane = memDataOut[{addr_lo_q[1], 4'b0000} +: 16];

  always_comb begin
    load_val = memDataOut;
    merged   = memDataOut;
    case (size_q)
      2'b00: begin
        load_val = {{24{signed_q & byte_lane[7]}}, byte_lane};
        merged[{addr_lo_q, 3'b000} +: 8] = data_q[7:0];
      end
      2'b01: begin
        load_val = {{16{signed_q & half_lane[15]}}, half_lane};
        merged[{addr_lo_q[1], 4'b0000} +: 16] = data_q[15:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Write strobe is decoded from state so a reset mid-store kills it at once.
  always_comb begin
    state_d        = state_q;
    reqReady       = 1'b0;
    respValid      = 1'b0;
    memWriteEnable = 1'b0;
    memDataIn      = '0;
    case (state_q)
      IDLE: begin
        reqReady = 1'b1;
        if (reqValid) state_d = req_err ? RESP : ISSUE;
      end
      ISSUE: begin
        if (write_q && size_q == 2'b10) begin
          memWriteEnable = 1'b1;
          memDataIn      = data_q;
          state_d        = RESP;
        end else if (write_q) begin
          state_d = MERGE;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: state_d = RESP;
      MERGE: begin
        memWriteEnable = 1'b1;
        memDataIn      = merged;
        state_d        = RESP;
      end
      RESP: begin
        respValid = 1'b1;
        if (respReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      write_q    <= 1'b0;
      signed_q   <= 1'b0;
      size_q     <= 2'b00;
      addr_lo_q  <= 2'b00;
      data_q     <= '0;
      respData   <= '0;
      respError  <= 1'b0;
      memAddress <= '0;
    end else begin
      if (state_q == IDLE && reqValid) begin
        write_q   <= reqWrite;
        signed_q  <= reqSigned;
        size_q    <= reqSize;
        addr_lo_q <= reqAddr[1:0];
        data_q    <= reqData;
        respData  <= '0;
        respError <= req_err;
        if (!req_err) memAddress <= addresswidth'(word_idx);
      end
      if (state_q == CAPTURE) respData <= load_val;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a registered, write-first memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        resetN;
  logic        reqValid, reqReady, reqWrite, reqSigned;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr, reqData;
  logic        respValid, respReady, respError;
  logic [31:0] respData;
  logic [31:0] memAddress;
  logic        memWriteEnable;
  logic [31:0] memDataIn, memDataOut;

  logic [31:0] mem [0:255];
  int          wr_cnt = 0;
  logic [31:0] wr_last = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.addresswidth(32), .depth(100000), .width(32)) dut (
    .clk(clk), .resetN(resetN),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqSize(reqSize), .reqSigned(reqSigned), .reqAddr(reqAddr), .reqData(reqData),
    .respValid(respValid), .respReady(respReady), .respData(respData), .respError(respError),
    .memAddress(memAddress), .memWriteEnable(memWriteEnable),
    .memDataIn(memDataIn), .memDataOut(memDataOut)
  );

  always @(posedge clk) begin
    if (memWriteEnable) begin
      mem[memAddress[7:0]] <= memDataIn;
      memDataOut           <= memDataIn;
      wr_cnt               <= wr_cnt + 1;
      wr_last              <= memDataIn;
    end else begin
      memDataOut <= mem[memAddress[7:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction with respReady high; returns at the negedge where respValid is seen.
  task automatic run(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_data, input logic exp_err,
                     input int exp_lat, input int exp_wr);
    int n;
    int lat;
    int wr0;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = w; reqSize = sz; reqSigned = sg;
    reqAddr = a; reqData = d; respReady = 1'b1;
    n = 0;
    while (!reqReady && n < 20) begin @(negedge clk); n++; end
    wr0 = wr_cnt;
    @(negedge clk);
    reqValid = 1'b0;
    lat = 1;
    while (!respValid && lat < 20) begin @(negedge clk); lat++; end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, respData, exp_data);
    check({tag, "_err"}, {31'b0, respError}, {31'b0, exp_err});
    check({tag, "_writes"}, wr_cnt - wr0, exp_wr);
  endtask

  initial begin
    int n;
    int wr0;
    resetN = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00;
    reqSigned = 1'b0; reqAddr = '0; reqData = '0; respReady = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    check("rst_reqReady", {31'b0, reqReady}, 32'd1);
    check("rst_respValid", {31'b0, respValid}, 32'd0);
    check("rst_respData", respData, 32'd0);
    check("rst_respError", {31'b0, respError}, 32'd0);
    check("rst_memAddress", memAddress, 32'd0);
    check("rst_we", {31'b0, memWriteEnable}, 32'd0);
    check("rst_memDataIn", memDataIn, 32'd0);

    // word store / load round trip
    run("st_w10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
    check("st_w10_addr", memAddress, 32'd4);
    check("st_w10_wdata", wr_last, 32'hDEADBEEF);
    run("ld_w10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);

    // lane extraction
    run("st_w20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF7F01, 32'h0, 1'b0, 2, 1);
    run("ld_b21s", 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'h0000007F, 1'b0, 3, 0);
    run("ld_b21u", 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'h0000007F, 1'b0, 3, 0);
    run("ld_b22s", 1'b0, 2'b00, 1'b1, 32'h22, 32'h0, 32'hFFFFFFFF, 1'b0, 3, 0);
    run("ld_b22u", 1'b0, 2'b00, 1'b0, 32'h22, 32'h0, 32'h000000FF, 1'b0, 3, 0);
    run("ld_b23s", 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0, 3, 0);
    run("ld_h22s", 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'hFFFF80FF, 1'b0, 3, 0);
    run("ld_h20s", 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h00007F01, 1'b0, 3, 0);

    // sub-word read-modify-write
    run("st_w30", 1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344, 32'h0, 1'b0, 2, 1);
    run("st_b31", 1'b1, 2'b00, 1'b0, 32'h31, 32'hFFFFFFAA, 32'h0, 1'b0, 3, 1);
    check("st_b31_wdata", wr_last, 32'h1122AA44);
    run("ld_w30a", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h1122AA44, 1'b0, 3, 0);
    run("st_h32", 1'b1, 2'b01, 1'b0, 32'h32, 32'h1234BEEF, 32'h0, 1'b0, 3, 1);
    run("ld_w30b", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'hBEEFAA44, 1'b0, 3, 0);

    // rejected requests: no memory traffic
    run("err_h3", 1'b0, 2'b01, 1'b1, 32'h3, 32'h0, 32'h0, 1'b1, 1, 0);
    run("err_w2", 1'b1, 2'b10, 1'b0, 32'h2, 32'hCAFEF00D, 32'h0, 1'b1, 1, 0);
    run("err_sz3", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0);
    run("err_range", 1'b0, 2'b10, 1'b0, 32'd400000, 32'h0, 32'h0, 1'b1, 1, 0);
    run("ok_last", 1'b1, 2'b10, 1'b0, 32'd399996, 32'h5A5A5A5A, 32'h0, 1'b0, 2, 1);
    check("ok_last_addr", memAddress, 32'd99999);

    // response backpressure while reqValid stays high
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'b10; reqSigned = 1'b0;
    reqAddr = 32'h10; reqData = 32'h0; respReady = 1'b0;
    n = 0;
    while (!respValid && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      check("bp_respValid", {31'b0, respValid}, 32'd1);
      check("bp_respData", respData, 32'hDEADBEEF);
      check("bp_respError", {31'b0, respError}, 32'd0);
      check("bp_reqReady", {31'b0, reqReady}, 32'd0);
      @(negedge clk);
    end
    respReady = 1'b1;
    @(negedge clk);
    check("bp_idle_reqReady", {31'b0, reqReady}, 32'd1);
    check("bp_idle_respValid", {31'b0, respValid}, 32'd0);
    @(negedge clk);
    check("bp_accept_reqReady", {31'b0, reqReady}, 32'd0);
    reqValid = 1'b0;
    n = 0;
    while (!respValid && n < 20) begin @(negedge clk); n++; end
    check("bp_second_lat", n, 2);
    check("bp_second_data", respData, 32'hDEADBEEF);

    // reset during MERGE aborts the write
    run("st_w40", 1'b1, 2'b10, 1'b0, 32'h40, 32'h55667788, 32'h0, 1'b0, 2, 1);
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b00; reqSigned = 1'b0;
    reqAddr = 32'h40; reqData = 32'h00000099; respReady = 1'b1;
    @(negedge clk);
    reqValid = 1'b0;
    @(negedge clk);
    check("mrg_we", {31'b0, memWriteEnable}, 32'd1);
    check("mrg_wdata", memDataIn, 32'h55667799);
    wr0 = wr_cnt;
    #1 resetN = 1'b0;
    #1;
    check("mrg_rst_we", {31'b0, memWriteEnable}, 32'd0);
    check("mrg_rst_wdata", memDataIn, 32'd0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    check("mrg_post_reqReady", {31'b0, reqReady}, 32'd1);
    check("mrg_post_respValid", {31'b0, respValid}, 32'd0);
    check("mrg_post_writes", wr_cnt - wr0, 0);
    check("mrg_post_mem", mem[8'd16], 32'h55667788);
    run("ld_w40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h55667788, 1'b0, 3, 0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side front end for the single-port word data memory.
- Accepts byte-addressed load/store requests from the CPU datapath over a valid/ready handshake.
- Drives the memory's clk-synchronous port and returns a response over a second valid/ready handshake.
- Handles byte and half-word access: lane extraction with sign/zero extension for loads, read-modify-write for sub-word stores.
- Flags misaligned, illegal-size and out-of-range requests without touching memory.

Parameters:
- addresswidth, 32, width of memAddress (word index).
- depth, 100000, number of words in the attached memory; word indices >= depth are out of range.
- width, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  rising-edge clock.
- resetN  in  1  asynchronous, active-low reset.
- reqValid  in  1  request present.
- reqReady  out  1  unit can accept a request.
- reqWrite  in  1  1 = store, 0 = load.
- reqSize  in  2  00 byte, 01 half, 10 word, 11 illegal.
- reqSigned  in  1  load sign-extends when 1; ignored for stores.
- reqAddr  in  32  byte address.
- reqData  in  32  store data, right-aligned.
- respValid  out  1  response present.
- respReady  in  1  consumer takes the response.
- respData  out  32  load result, right-aligned and extended; 0 for stores and errors.
- respError  out  1  request rejected; no memory access performed.
- memAddress  out  addresswidth  word index, reqAddr[31:2] zero-extended or truncated.
- memWriteEnable  out  1  memory write strobe.
- memDataIn  out  32  memory write data.
- memDataOut  in  32  memory read data; registered, valid the cycle after memAddress is presented; write-first.

Behaviour:
- States: IDLE, ISSUE, CAPTURE, MERGE, RESP.
- Reset (async, resetN=0): state IDLE; reqReady=1 after release; respValid=0; respData=0; respError=0; memAddress=0; memWriteEnable=0; memDataIn=0.
- Reset mid-operation: memWriteEnable drops immediately because it is decoded from state. A pending request is discarded and no response is issued.
- IDLE:
  - reqReady=1. Accept on reqValid&&reqReady at a rising edge; latch write, size, signed, addr and data.
  - Error if: size==11; half with addr[0]!=0; word with addr[1:0]!=0; or reqAddr[31:2] >= depth.
  - On error: go to RESP with respError=1 and respData=0. No memory cycle.
  - Otherwise go to ISSUE.
- reqReady=0 in every state except IDLE. reqReady has no combinational path from respReady.
- ISSUE (1 cycle):
  - memAddress = latched word index.
  - Word store: memWriteEnable=1 and memDataIn=reqData; next state RESP.
  - Load: memWriteEnable=0; next state CAPTURE.
  - Sub-word store: memWriteEnable=0; next state MERGE.
- CAPTURE:
  - Extract the lane from memDataOut. Lanes are little-endian: byte k = bits [8k+7:8k] with k=addr[1:0]; half at offset 0 or 2.
  - Zero- or sign-extend the lane, register it into respData, go to RESP.
- MERGE:
  - memWriteEnable=1; memDataIn = memDataOut with the addressed lane replaced by reqData[7:0] or reqData[15:0]; other lanes unchanged.
  - Next state RESP.
- RESP: respValid=1 and respData/respError are held stable until respReady=1 at an edge, then go to IDLE. A new request is accepted no earlier than the following cycle.
- Latency from the accept edge to respValid: error 1 cycle, word store 2, load 3, sub-word store 3.
- Outside ISSUE and MERGE, memWriteEnable=0. memDataIn is 0 when not writing. memAddress holds its last value.
- Exactly one memory write per store. No write for loads or errors.

Test Plan:
- Word store addr=0x10, data=0xDEADBEEF, then word load addr=0x10 -> memAddress=4 with one write pulse; load respData=0xDEADBEEF after 3 cycles, respError=0.
- Word 0x80FF7F01 at addr 0x20; byte loads at 0x21 signed and unsigned -> 0x0000007F and 0x0000007F; byte load 0x22 signed -> 0xFFFFFFFF; half load 0x22 signed -> 0xFFFF80FF.
- Word at 0x30 = 0x11223344; byte store 0xAA to 0x31 -> one read cycle then one write of memDataIn=0x1122AA44; follow-up word load returns 0x1122AA44.
- Half load at 0x3, word store at 0x2, size=11, and word addr 4*depth -> respError=1, respData=0, memWriteEnable never asserted.
- respReady held 0 for 5 cycles during RESP -> respValid, respData and respError stable; reqReady=0 throughout; reqValid held high is accepted only after the handshake completes.
- Assert resetN=0 during MERGE -> memWriteEnable=0 immediately; after release state is IDLE, reqReady=1, respValid=0, and memory retains its pre-store value.
